// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and its load aligner.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU      = 2'd0,
    WB_DATA_MEM = 2'd1,
    WB_PC       = 2'd2,
    WB_IMM      = 2'd3
  } wb_sel_e;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_e;

  // Load size/sign codes as they appear in the instruction funct3 field
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Width of the memory-wait counter; large enough for timeouts up to 255
  localparam int WB_CNT_W = 8;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the addressed byte/halfword/word lane
// out of a data-memory word and sign- or zero-extends it to XLEN.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_lsb,
  output logic [XLEN-1:0] aligned
);

  localparam int LANE_W = $clog2(XLEN / 8);

  logic [LANE_W-1:0] byte_idx;
  logic [LANE_W-1:0] half_idx;
  logic [LANE_W-1:0] word_idx;
  logic [7:0]        byte_val;
  logic [15:0]       half_val;
  logic [31:0]       word_val;
  logic              unused_lsb;

  // Misaligned low-order address bits are dropped by masking the lane index
  assign byte_idx = addr_lsb[LANE_W-1:0];
  assign half_idx = byte_idx & ~LANE_W'(1);
  assign word_idx = byte_idx & ~LANE_W'(3);

  assign byte_val = 8'(data >> {byte_idx, 3'b000});
  assign half_val = 16'(data >> {half_idx, 3'b000});
  assign word_val = 32'(data >> {word_idx, 3'b000});

  // Upper address bits are meaningless for narrow datapaths
  assign unused_lsb = ^addr_lsb;

  // Extend the selected lane according to the load size/sign code
  always_comb begin
    aligned = data;
    case (funct3)
      F3_LB:   aligned = XLEN'($signed(byte_val));
      F3_LH:   aligned = XLEN'($signed(half_val));
      F3_LBU:  aligned = XLEN'(byte_val);
      F3_LHU:  aligned = XLEN'(half_val);
      F3_LW:   aligned = XLEN'($signed(word_val));
      F3_LWU:  aligned = XLEN'(word_val);
      default: aligned = data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Registered writeback stage: selects rd data from ALU/memory/PC+inc/IMM,
// waits on variable-latency memory responses with a timeout, and drives a
// one-cycle register-file write pulse.
// Optional feature macro: WB_INSTRET_EN (adds a 64-bit retired-instruction counter).
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int PC_INC      = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic [1:0]            in_sel,
  input  logic                  in_rd_we,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]       in_alu_data,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [2:0]            in_funct3,
  input  logic [2:0]            in_addr_lsb,
  input  logic                  dm_rsp_valid,
  input  logic [XLEN-1:0]       dm_rsp_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  busy,
  output logic                  timeout_err
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]           instret
`endif
);

  wb_state_e             state;
  wb_state_e             next_state;
  logic [WB_CNT_W-1:0]   wait_cnt;
  logic [WB_CNT_W-1:0]   wait_cnt_next;

  logic                  ld_rd_we;
  logic [REG_ADDR_W-1:0] ld_rd_addr;
  logic [2:0]            ld_funct3;
  logic [2:0]            ld_addr_lsb;

  logic                  accept;
  logic                  capture;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  set_timeout;
  logic                  complete;
  logic [XLEN-1:0]       load_data;

  assign in_ready = (state == WB_IDLE);
  assign busy     = (state == WB_WAIT_MEM);
  assign accept   = in_valid && in_ready && !flush;

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .data     (dm_rsp_data),
    .funct3   (ld_funct3),
    .addr_lsb (ld_addr_lsb),
    .aligned  (load_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and write decision; flush overrides both response and timeout
  always_comb begin
    next_state    = state;
    wait_cnt_next = wait_cnt;
    capture       = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    set_timeout   = 1'b0;
    complete      = 1'b0;
    case (state)
      WB_IDLE: begin
        if (accept) begin
          if (wb_sel_e'(in_sel) == WB_DATA_MEM) begin
            capture       = 1'b1;
            wait_cnt_next = '0;
            next_state    = WB_WAIT_MEM;
          end else begin
            complete = 1'b1;
            wr_en    = in_rd_we && (in_rd_addr != '0);
            wr_addr  = in_rd_addr;
            case (wb_sel_e'(in_sel))
              WB_PC:   wr_data = in_pc + XLEN'(PC_INC);
              WB_IMM:  wr_data = in_imm;
              default: wr_data = in_alu_data;
            endcase
          end
        end
      end
      WB_WAIT_MEM: begin
        if (flush) begin
          next_state = WB_IDLE;
        end else if (dm_rsp_valid) begin
          complete   = 1'b1;
          wr_en      = ld_rd_we && (ld_rd_addr != '0);
          wr_addr    = ld_rd_addr;
          wr_data    = load_data;
          next_state = WB_IDLE;
        end else if (wait_cnt == WB_CNT_W'(MEM_TIMEOUT - 1)) begin
          set_timeout = 1'b1;
          next_state  = WB_IDLE;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      default: next_state = WB_IDLE;
    endcase
  end

  // Wait counter and captured load attributes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      ld_rd_we    <= 1'b0;
      ld_rd_addr  <= '0;
      ld_funct3   <= '0;
      ld_addr_lsb <= '0;
    end else begin
      wait_cnt <= wait_cnt_next;
      if (capture) begin
        ld_rd_we    <= in_rd_we;
        ld_rd_addr  <= in_rd_addr;
        ld_funct3   <= in_funct3;
        ld_addr_lsb <= in_addr_lsb;
      end
    end
  end

  // Register-file write port; address/data only change on a real write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_en;
      if (wr_en) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
      end
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (set_timeout) begin
      timeout_err <= 1'b1;
    end
  end

`ifdef WB_INSTRET_EN
  // Count completed instructions, including non-writing ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (complete) begin
      instret <= instret + 64'd1;
    end
  end
`else
  logic unused_complete;
  assign unused_complete = complete;
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Registered writeback stage of the RISC-V pipeline. It replaces the combinational writeback mux with a valid/ready stage that selects the destination-register data from ALU, data-memory, PC+4 or immediate sources. It waits on a variable-latency data-memory response and aligns and sign- or zero-extends sub-word loads. It drives the register-file write port with a one-cycle write pulse and supports flush and memory-timeout handling.

Parameters:
XLEN, 32, datapath width (32 or 64)
REG_ADDR_W, 5, register-file address width
PC_INC, 4, increment added to PC for the link value
MEM_TIMEOUT, 16, max cycles spent waiting for dm_rsp_valid (2..255)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept (high only in IDLE)
flush  input  1  kill the accepted/pending instruction
in_sel  input  2  writeback select: 0 ALU, 1 DATA_MEM, 2 PC, 3 IMM
in_rd_we  input  1  instruction writes rd
in_rd_addr  input  REG_ADDR_W  destination register
in_alu_data  input  XLEN  ALU result
in_pc  input  XLEN  instruction PC
in_imm  input  XLEN  immediate (LUI)
in_funct3  input  3  load size/sign code
in_addr_lsb  input  3  low bits of load address
dm_rsp_valid  input  1  data-memory read data valid
dm_rsp_data  input  XLEN  data-memory read word
rf_we  output  1  register-file write pulse
rf_waddr  output  REG_ADDR_W  write address
rf_wdata  output  XLEN  write data
busy  output  1  in WAIT_MEM
timeout_err  output  1  sticky memory-timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0; timeout_err=0; wait counter=0.
  - Release takes effect on the next clk edge.
- FSM states: IDLE, WAIT_MEM. in_ready = (state==IDLE); busy = (state==WAIT_MEM).
- Accept = in_valid && in_ready && !flush. flush in the accept cycle drops the instruction; no write occurs.
- Non-load accept (in_sel != 1):
  - Latency 1: rf_we = in_rd_we && (in_rd_addr != 0) on the next cycle, for exactly one cycle.
  - rf_waddr = in_rd_addr.
  - rf_wdata: ALU → in_alu_data; PC → (in_pc + PC_INC) mod 2^XLEN; IMM → in_imm.
  - FSM stays in IDLE.
- Load accept (in_sel == 1):
  - Capture rd_we, rd_addr, funct3 and addr_lsb; go to WAIT_MEM; clear the wait counter.
  - dm_rsp_valid is ignored in IDLE and in the accept cycle.
- In WAIT_MEM:
  - dm_rsp_valid: next cycle rf_we pulses (same x0 rule) with the aligned data; return to IDLE.
  - No response: counter increments. Counter == MEM_TIMEOUT-1 without a response: set timeout_err (sticky until reset), no write, return to IDLE.
  - flush: return to IDLE next cycle with no write. flush wins over a same-cycle dm_rsp_valid and over a timeout.
- Load alignment:
  - Byte lane = in_addr_lsb[log2(XLEN/8)-1:0]; halfword/word lanes use the upper bits of that field.
  - Low-order misalignment is ignored.
  - funct3 000 LB sext8, 001 LH sext16, 100 LBU zext8, 101 LHU zext16.
  - 010 LW: full word at XLEN=32; sext32 at XLEN=64.
  - 110 LWU: zext32 (XLEN=64; full word at 32).
  - 011 LD: full word.
  - 111: treated as a full-word load.
- rf_waddr and rf_wdata hold their last values while rf_we=0.

Optional Feature:
WB_INSTRET_EN
- With it defined: adds a 64-bit output instret, reset to 0. It increments by 1 in each cycle that completes an instruction: a non-load write cycle (even if rd=x0 or in_rd_we=0) or a load response. Flushed or timed-out instructions are not counted. Wraps at 2^64.
- Without it: the instret port and counter are absent.

Decomposition:
- Shared package wb_pkg:
  - typedef enum logic [1:0] wb_sel_e {WB_ALU, WB_DATA_MEM, WB_PC, WB_IMM}.
  - typedef enum logic wb_state_e {WB_IDLE, WB_WAIT_MEM}.
  - Load funct3 localparams (F3_LB ... F3_LWU).
- One natural sub-module: load_align, purely combinational (dm_rsp_data, funct3, addr_lsb → aligned XLEN data).

Test Plan:
- ALU path: in_sel=0, rd=5, alu=0x1234_5678 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678; one-cycle pulse.
- PC path wrap: in_sel=2, pc=0xFFFF_FFFC, rd=1 → rf_wdata=0x0000_0000.
- LB sign: funct3=000, lsb=2, response 3 cycles later with data 0x0080_0000 → rf_wdata=0xFFFF_FF80, in_ready low for 3 cycles.
- LHU: funct3=101, lsb=2, data 0xBEEF_0000 → rf_wdata=0x0000_BEEF.
- Timeout: load with no response, MEM_TIMEOUT=16 → timeout_err=1 after 16 cycles in WAIT_MEM, rf_we stays 0, in_ready returns high.
- Flush and x0:
  - flush asserted in WAIT_MEM together with dm_rsp_valid → no write, IDLE next cycle.
  - in_rd_addr=0 with ALU data 0xFFFF_FFFF → rf_we stays 0.
